// File: rtl/vcm_pkg.sv
// vcm_pkg: shared state encoding and constants for the VCM read path.
package vcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO_HI,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE,
    ST_GAP
  } seq_state_e;

  localparam int DEF_PERIOD  = 50000;
  localparam int DEF_GO_W    = 4;
  localparam int DEF_TIMEOUT = 4096;

  // 7-bit I2C address of the VCM driver, also used by the reader instance
  localparam logic [6:0] VCM_SLAVE_ADDR = 7'h18;

endpackage

// File: rtl/vcm_cycle_timer.sv
// vcm_cycle_timer: loadable down-counter that parks at zero and flags expiry.
module vcm_cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_d, count_q;

  // Clear beats load, load beats counting; the count stops at zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/vcm_read_sequencer.sv
// vcm_read_sequencer: drives the VCM reader GO/END_OK handshake periodically or on
// request, qualifies each transfer by its address ACK and publishes 16-bit samples.
module vcm_read_sequencer
  import vcm_pkg::*;
#(
  parameter int PERIOD  = DEF_PERIOD,
  parameter int GO_W    = DEF_GO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        EN,
  input  logic        REQ,
  output logic        RD_GO,
  input  logic        RD_END_OK,
  input  logic        RD_ACK_OK,
  input  logic [15:0] RD_DATA16,
  output logic [15:0] DATA,
  output logic        VALID,
  output logic        CHANGED,
  output logic        NACK,
  output logic        TMO,
  input  logic        CLR,
  output logic        BUSY,
  output logic [15:0] RD_CNT
);

  localparam int PER_W   = $clog2(PERIOD);
  localparam int TMR_MAX = (TIMEOUT > GO_W) ? TIMEOUT : GO_W;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // The GAP->IDLE->GO_HI hop costs two cycles after expiry, hence PERIOD-2
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD - 2);
  localparam logic [TMR_W-1:0] GO_LOAD  = TMR_W'(GO_W - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT - 1);

  seq_state_e  state_d, state_q;
  logic        rd_go_d, rd_go_q;
  logic [15:0] data_d, data_q;
  logic        valid_d, valid_q;
  logic        changed_d, changed_q;
  logic        nack_d, nack_q;
  logic        tmo_d, tmo_q;
  logic        busy_d, busy_q;
  logic [15:0] rd_cnt_d, rd_cnt_q;
  logic        ack_seen_d, ack_seen_q;
  logic        req_mode_d, req_mode_q;
  logic        have_sample_d, have_sample_q;

  logic             per_load, per_expired;
  logic             tmr_load, tmr_expired;
  logic [TMR_W-1:0] tmr_load_val;

  // Period timer: held at zero while auto mode is off, reloaded on every GO launch
  vcm_cycle_timer #(.WIDTH(PER_W)) u_period_timer (
    .clk      (PT_CK),
    .rst_n    (RESET_N),
    .clear    (!EN),
    .load     (per_load),
    .load_val (PER_LOAD),
    .expired  (per_expired)
  );

  // Phase timer: times the GO pulse width, then the WAIT_BUSY/WAIT_DONE timeouts
  vcm_cycle_timer #(.WIDTH(TMR_W)) u_phase_timer (
    .clk      (PT_CK),
    .rst_n    (RESET_N),
    .clear    (1'b0),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // Next-state logic; the sample is captured on the WAIT_DONE->CAPTURE edge so
  // VALID and DATA appear in the CAPTURE cycle straight from flops
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    changed_d     = 1'b0;
    nack_d        = nack_q & ~CLR;
    tmo_d         = tmo_q & ~CLR;
    rd_cnt_d      = rd_cnt_q;
    ack_seen_d    = ack_seen_q;
    req_mode_d    = req_mode_q;
    have_sample_d = have_sample_q;
    per_load      = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = TMO_LOAD;

    case (state_q)
      ST_IDLE: begin
        if ((EN && per_expired) || REQ) begin
          state_d      = ST_GO_HI;
          req_mode_d   = !(EN && per_expired);
          per_load     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = GO_LOAD;
        end
      end
      ST_GO_HI: begin
        if (tmr_expired) begin
          state_d  = ST_WAIT_BUSY;
          tmr_load = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (!RD_END_OK) begin
          state_d    = ST_WAIT_DONE;
          ack_seen_d = 1'b0;
          tmr_load   = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_GAP;
          tmo_d   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (RD_ACK_OK) begin
          ack_seen_d = 1'b1;
        end
        if (RD_END_OK) begin
          state_d = ST_CAPTURE;
          if (ack_seen_q || RD_ACK_OK) begin
            data_d        = RD_DATA16;
            valid_d       = 1'b1;
            changed_d     = !have_sample_q || (RD_DATA16 != data_q);
            have_sample_d = 1'b1;
            rd_cnt_d      = rd_cnt_q + 16'd1;
          end else begin
            nack_d = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = ST_GAP;
          tmo_d   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (req_mode_q ? !REQ : (!EN || per_expired)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_go_d = (state_d == ST_GO_HI);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge PT_CK) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      rd_go_q       <= 1'b0;
      data_q        <= 16'h0000;
      valid_q       <= 1'b0;
      changed_q     <= 1'b0;
      nack_q        <= 1'b0;
      tmo_q         <= 1'b0;
      busy_q        <= 1'b0;
      rd_cnt_q      <= 16'h0000;
      ack_seen_q    <= 1'b0;
      req_mode_q    <= 1'b0;
      have_sample_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_go_q       <= rd_go_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      changed_q     <= changed_d;
      nack_q        <= nack_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      rd_cnt_q      <= rd_cnt_d;
      ack_seen_q    <= ack_seen_d;
      req_mode_q    <= req_mode_d;
      have_sample_q <= have_sample_d;
    end
  end

  assign RD_GO   = rd_go_q;
  assign DATA    = data_q;
  assign VALID   = valid_q;
  assign CHANGED = changed_q;
  assign NACK    = nack_q;
  assign TMO     = tmo_q;
  assign BUSY    = busy_q;
  assign RD_CNT  = rd_cnt_q;

endmodule

// File: tb/tb_vcm_read_sequencer.sv
// tb_vcm_read_sequencer: self-checking bench with a behavioural VCM reader model.
module tb_vcm_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, req, clr;
  logic        rd_go, rd_end_ok, rd_ack_ok;
  logic [15:0] rd_data16;
  logic [15:0] data, rd_cnt;
  logic        valid, changed, nack, tmo, busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  // reader model controls
  int          rdr_mode;      // 0 normal, 1 END_OK stuck high, 2 END_OK stuck low
  bit          rdr_ack;
  logic [15:0] rdr_data;
  int          rdr_busy_len;
  logic [15:0] auto_vals[$];

  // reader model internal state
  logic go_prev;
  bit   rdr_pend, rdr_busy;
  int   rdr_cnt;

  // observations from applyStimulus
  int obs_go, obs_valid, obs_changed;

  typedef struct {
    bit          ack;
    logic [15:0] rdata;
    int          busy_len;
    int          exp_valid;
    int          exp_changed;
    logic [15:0] exp_data;
    logic [15:0] exp_cnt;
    bit          exp_nack;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  vcm_read_sequencer #(.PERIOD(200), .GO_W(4), .TIMEOUT(64)) dut (
    .PT_CK     (clk),
    .RESET_N   (rst_n),
    .EN        (en),
    .REQ       (req),
    .RD_GO     (rd_go),
    .RD_END_OK (rd_end_ok),
    .RD_ACK_OK (rd_ack_ok),
    .RD_DATA16 (rd_data16),
    .DATA      (data),
    .VALID     (valid),
    .CHANGED   (changed),
    .NACK      (nack),
    .TMO       (tmo),
    .CLR       (clr),
    .BUSY      (busy),
    .RD_CNT    (rd_cnt)
  );

  // Reader model: END_OK drops two cycles after GO falls, ACK_OK pulses mid-transfer
  // and is cleared at completion, when END_OK returns high with the new data
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_end_ok <= 1'b1;
      rd_ack_ok <= 1'b0;
      rd_data16 <= 16'h0000;
      go_prev   <= 1'b0;
      rdr_pend  <= 1'b0;
      rdr_busy  <= 1'b0;
      rdr_cnt   <= 0;
    end else begin
      go_prev <= rd_go;
      if (rdr_mode == 1) begin
        rd_end_ok <= 1'b1;
        rd_ack_ok <= 1'b0;
      end else if (go_prev && !rd_go) begin
        rdr_pend <= 1'b1;
      end else if (rdr_pend) begin
        rdr_pend  <= 1'b0;
        rd_end_ok <= 1'b0;
        rdr_busy  <= 1'b1;
        rdr_cnt   <= rdr_busy_len;
      end else if (rdr_busy && rdr_mode == 0) begin
        if (rdr_cnt > 1) begin
          rdr_cnt   <= rdr_cnt - 1;
          rd_ack_ok <= rdr_ack && (rdr_cnt <= rdr_busy_len - 1) && (rdr_cnt > 2);
        end else begin
          rd_end_ok <= 1'b1;
          rd_ack_ok <= 1'b0;
          rdr_busy  <= 1'b0;
          if (auto_vals.size() > 0) rd_data16 <= auto_vals.pop_front();
          else rd_data16 <= rdr_data;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_flags"}, {26'd0, rd_go, valid, changed, nack, tmo, busy}, 32'd0);
    checkOutput({tag, "_data"}, data, 32'd0);
    checkOutput({tag, "_cnt"}, rd_cnt, 32'd0);
  endtask

  // One REQ-initiated read; REQ is held req_cycles, observation runs until BUSY drops
  task automatic applyStimulus(input bit ack, input logic [15:0] d, input int req_cycles,
                               input int busy_len);
    bit done = 1'b0;
    rdr_ack = ack;
    rdr_data = d;
    rdr_busy_len = busy_len;
    obs_go = 0;
    obs_valid = 0;
    obs_changed = 0;
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == req_cycles - 1) req = 1'b0;
      if (rd_go) obs_go++;
      if (valid) obs_valid++;
      if (changed) obs_changed++;
      if (i > 0 && !busy && !req) begin
        done = 1'b1;
        break;
      end
    end
    req = 1'b0;
    checkOutput("read_done", done, 1);
  endtask

  // Stuck-reader read; measures cycles from GO falling to TMO rising
  task automatic runTimeout(input int mode, input int exp_cycles, input string nm);
    int k = -1;
    bit go_seen = 1'b0;
    bit hit = 1'b0;
    bit idle_back = 1'b0;
    int vcount = 0;
    rdr_mode = mode;
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (k >= 0) k++;
      if (go_seen && !rd_go && k < 0) k = 0;
      if (rd_go) go_seen = 1'b1;
      if (valid) vcount++;
      if (tmo) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput({nm, "_delay"}, hit ? k : -1, exp_cycles);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) vcount++;
      if (!busy) begin
        idle_back = 1'b1;
        break;
      end
    end
    checkOutput({nm, "_idle"}, idle_back, 1);
    checkOutput({nm, "_no_valid"}, vcount, 0);
    checkOutput({nm, "_sticky"}, tmo, 1);
  endtask

  initial begin
    int          go_t[$];
    int          ch_bits[$];
    int          cyc, pat, extra_go;
    bit          prev_go, ok;
    logic [15:0] m_data, m_cnt, d;
    bit          m_nack, m_have, ack, exp_ch;

    vecs[0] = '{1'b1, 16'h1234, 10, 1, 0, 16'h1234, 16'd2, 1'b0};
    vecs[1] = '{1'b1, 16'hBEEF,  4, 1, 1, 16'hBEEF, 16'd3, 1'b0};
    vecs[2] = '{1'b0, 16'h5555, 15, 0, 0, 16'hBEEF, 16'd3, 1'b1};
    vecs[3] = '{1'b1, 16'h0000,  6, 1, 1, 16'h0000, 16'd4, 1'b1};
    vecs[4] = '{1'b1, 16'h0000, 20, 1, 0, 16'h0000, 16'd5, 1'b1};

    rst_n = 1'b0; en = 1'b0; req = 1'b0; clr = 1'b0;
    rdr_mode = 0; rdr_ack = 1'b1; rdr_data = 16'h0000; rdr_busy_len = 10;

    $display("[TB] reset values");
    doReset(3);
    @(negedge clk);
    checkResetValues("reset");

    $display("[TB] single read");
    applyStimulus(1'b1, 16'h1234, 3, 10);
    checkOutput("single_go_width", obs_go, 4);
    checkOutput("single_valid", obs_valid, 1);
    checkOutput("single_changed", obs_changed, 1);
    checkOutput("single_data", data, 16'h1234);
    checkOutput("single_cnt", rd_cnt, 1);
    extra_go = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_go) extra_go++;
    end
    checkOutput("single_no_second_go", extra_go, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].ack, vecs[i].rdata, 3, vecs[i].busy_len);
      checkOutput($sformatf("vec%0d_valid", i), obs_valid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_changed", i), obs_changed, vecs[i].exp_changed);
      checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_cnt", i), rd_cnt, vecs[i].exp_cnt);
      checkOutput($sformatf("vec%0d_nack", i), nack, vecs[i].exp_nack);
    end
    pulseClr();
    checkOutput("clr_nack", nack, 0);

    $display("[TB] timeout with END_OK stuck high");
    runTimeout(1, 64, "tmo_hi");

    $display("[TB] reset during WAIT_DONE");
    rdr_mode = 0; rdr_ack = 1'b1; rdr_data = 16'h4242; rdr_busy_len = 20;
    @(negedge clk);
    req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (!rd_end_ok) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("midreset_reached_busy", ok, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] NACK");
    applyStimulus(1'b0, 16'h7777, 3, 10);
    checkOutput("nack_set", nack, 1);
    checkOutput("nack_no_valid", obs_valid, 0);
    checkOutput("nack_data", data, 0);
    checkOutput("nack_cnt", rd_cnt, 0);
    pulseClr();
    checkOutput("nack_clr", nack, 0);
    applyStimulus(1'b1, 16'hA5A5, 3, 8);
    checkOutput("after_reset_valid", obs_valid, 1);
    checkOutput("after_reset_changed", obs_changed, 1);
    checkOutput("after_reset_data", data, 16'hA5A5);
    checkOutput("after_reset_cnt", rd_cnt, 1);

    $display("[TB] timeout with END_OK stuck low");
    runTimeout(2, 67, "tmo_lo");
    pulseClr();
    checkOutput("tmo_clr", tmo, 0);
    rdr_mode = 0;
    doReset(2);

    $display("[TB] auto mode");
    rdr_ack = 1'b1; rdr_busy_len = 10;
    auto_vals.push_back(16'h0100);
    auto_vals.push_back(16'h0100);
    auto_vals.push_back(16'h0200);
    @(negedge clk);
    en = 1'b1;
    cyc = 0;
    prev_go = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (rd_go && !prev_go) go_t.push_back(cyc);
      prev_go = rd_go;
      if (valid) ch_bits.push_back(int'(changed));
      if (ch_bits.size() == 3) break;
    end
    en = 1'b0;
    pat = 0;
    foreach (ch_bits[i]) pat = (pat << 1) | ch_bits[i];
    checkOutput("auto_valid_count", ch_bits.size(), 3);
    checkOutput("auto_gap1", (go_t.size() >= 2) ? go_t[1] - go_t[0] : 0, 200);
    checkOutput("auto_gap2", (go_t.size() >= 3) ? go_t[2] - go_t[1] : 0, 200);
    checkOutput("auto_changed_pattern", pat, 3'b101);
    extra_go = 0;
    ok = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (rd_go) extra_go++;
      if (!busy) ok = 1'b1;
    end
    checkOutput("auto_back_idle", ok, 1);
    checkOutput("auto_stops_after_en", extra_go, 0);

    $display("[TB] randomized reads against reference model");
    doReset(2);
    m_data = 16'h0000; m_cnt = 16'h0000; m_nack = 1'b0; m_have = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        pulseClr();
        m_nack = 1'b0;
      end
      ack = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        0: d = m_data;
        1: d = 16'h0000;
        2: d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      applyStimulus(ack, d, $urandom_range(1, 6), $urandom_range(4, 20));
      exp_ch = 1'b0;
      if (ack) begin
        exp_ch = !m_have || (d != m_data);
        m_data = d;
        m_cnt  = m_cnt + 16'd1;
        m_have = 1'b1;
      end else begin
        m_nack = 1'b1;
      end
      checkOutput($sformatf("rnd%0d_valid", n), obs_valid, ack);
      checkOutput($sformatf("rnd%0d_changed", n), obs_changed, exp_ch);
      checkOutput($sformatf("rnd%0d_data", n), data, m_data);
      checkOutput($sformatf("rnd%0d_cnt", n), rd_cnt, m_cnt);
      checkOutput($sformatf("rnd%0d_nack", n), nack, m_nack);
    end

    $display("[TB] RD_CNT wrap");
    @(negedge clk);
    force dut.rd_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    @(negedge clk);
    checkOutput("wrap_preload", rd_cnt, 16'hFFFF);
    applyStimulus(1'b1, 16'h3C3C, 3, 6);
    checkOutput("wrap_valid", obs_valid, 1);
    checkOutput("wrap_cnt", rd_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global guard so a stuck handshake can never hang the run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
